// File: rtl/lms7_tx_burst_sched.sv
// Timestamp-gated TX burst scheduler: releases each descriptor's samples to the
// framer FIFO starting at the slot named by cmd_ts, or drains them if that slot has passed.
module lms7_tx_burst_sched #(
    parameter int TS_BITS  = 32,
    parameter int LEN_BITS = 16
) (
    input  logic                mclk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic                ts_tick,
    input  logic [TS_BITS-1:0]  cmd_ts,
    input  logic [LEN_BITS-1:0] cmd_len,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [47:0]         s_tdata,
    input  logic                s_tvalid,
    output logic                s_tready,
    output logic [47:0]         m_tdata,
    output logic                m_tvalid,
    input  logic                m_tready,
    output logic [TS_BITS-1:0]  ts_now,
    output logic                busy,
    output logic                stat_late,
    output logic                stat_underrun
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_ACTIVE  = 2'd2,
        ST_DISCARD = 2'd3
    } state_t;

    localparam logic [LEN_BITS-1:0] LEN_ZERO = {LEN_BITS{1'b0}};
    localparam logic [LEN_BITS-1:0] LEN_ONE  = {{(LEN_BITS-1){1'b0}}, 1'b1};

    state_t                r_state;
    state_t                w_state_nxt;
    logic [TS_BITS-1:0]    r_ts_now;
    logic [TS_BITS-1:0]    r_ts_tgt;
    logic [TS_BITS-1:0]    w_ts_nxt;
    logic [TS_BITS-1:0]    w_diff;
    logic [LEN_BITS-1:0]   r_remain;
    logic [LEN_BITS-1:0]   w_remain_nxt;
    logic                  r_run;
    logic                  r_stat_late;
    logic                  r_stat_underrun;
    logic                  w_tick;
    logic                  w_cmd_fire;
    logic                  w_cmd_ready;
    logic                  w_s_tready;
    logic                  w_m_tvalid;
    logic [47:0]           w_m_tdata;
    logic                  w_late;
    logic                  w_underrun;

    assign w_tick     = ts_tick & enable;
    assign w_ts_nxt   = r_ts_now + {{(TS_BITS-1){1'b0}}, w_tick};
    // WAIT looks one slot ahead so the first ACTIVE cycle sees ts_now == target.
    assign w_diff     = r_ts_tgt - w_ts_nxt;
    assign w_cmd_fire = w_cmd_ready & cmd_valid;

    // Next-state, remain update and the zero-latency stream path.
    always_comb begin
        w_state_nxt  = r_state;
        w_remain_nxt = r_remain;
        w_cmd_ready  = 1'b0;
        w_s_tready   = 1'b0;
        w_m_tvalid   = 1'b0;
        w_m_tdata    = 48'h0;
        w_late       = 1'b0;
        w_underrun   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cmd_ready = enable & r_run;
                if (w_cmd_fire) begin
                    w_remain_nxt = cmd_len;
                    if (cmd_len != LEN_ZERO) begin
                        w_state_nxt = ST_WAIT;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (w_diff == {TS_BITS{1'b0}}) begin
                    w_state_nxt = ST_ACTIVE;
                end else if (w_diff[TS_BITS-1]) begin
                    w_late      = 1'b1;
                    w_state_nxt = ST_DISCARD;
                end else begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_ACTIVE: begin
                w_m_tvalid = s_tvalid;
                w_m_tdata  = s_tdata;
                w_s_tready = m_tready;
                if (s_tvalid & m_tready) begin
                    w_remain_nxt = r_remain - LEN_ONE;
                    if (r_remain == LEN_ONE) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_ACTIVE;
                    end
                end else if (m_tready) begin
                    w_underrun = 1'b1;
                end else begin
                    w_state_nxt = ST_ACTIVE;
                end
            end
            ST_DISCARD: begin
                w_s_tready = 1'b1;
                if (s_tvalid) begin
                    w_remain_nxt = r_remain - LEN_ONE;
                    if (r_remain == LEN_ONE) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_DISCARD;
                    end
                end else begin
                    w_state_nxt = ST_DISCARD;
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_remain_nxt = LEN_ZERO;
            end
        endcase
        // Disabling drops whatever burst is pending.
        if (!enable) begin
            w_state_nxt  = ST_IDLE;
            w_remain_nxt = LEN_ZERO;
            w_late       = 1'b0;
            w_underrun   = 1'b0;
        end else begin
            w_state_nxt  = w_state_nxt;
        end
    end

    // State, counters, descriptor latch and registered status pulses.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= ST_IDLE;
            r_ts_now        <= {TS_BITS{1'b0}};
            r_ts_tgt        <= {TS_BITS{1'b0}};
            r_remain        <= LEN_ZERO;
            r_run           <= 1'b0;
            r_stat_late     <= 1'b0;
            r_stat_underrun <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_ts_now        <= w_ts_nxt;
            r_remain        <= w_remain_nxt;
            r_run           <= 1'b1;
            r_stat_late     <= w_late;
            r_stat_underrun <= w_underrun;
            if (w_cmd_fire) begin
                r_ts_tgt <= cmd_ts;
            end
        end
    end

    assign cmd_ready     = w_cmd_ready;
    assign s_tready      = w_s_tready;
    assign m_tvalid      = w_m_tvalid;
    assign m_tdata       = w_m_tdata;
    assign ts_now        = r_ts_now;
    assign busy          = (r_state != ST_IDLE);
    assign stat_late     = r_stat_late;
    assign stat_underrun = r_stat_underrun;

endmodule

// File: tb/tb_lms7_tx_burst_sched.sv
// Bench for lms7_tx_burst_sched: vector table, directed corner sequences and a
// randomized run, all checked against a slot/burst-level reference model.
module tb_lms7_tx_burst_sched;

    // A 12-bit timestamp keeps the counter wrap reachable in a few thousand cycles.
    localparam int TSB = 12;
    localparam int LB  = 8;
    localparam int TSM = 1 << TSB;

    logic           mclk = 1'b0;
    logic           rst_n = 1'b0;
    logic           enable = 1'b0;
    logic           ts_tick = 1'b0;
    logic [TSB-1:0] cmd_ts = '0;
    logic [LB-1:0]  cmd_len = '0;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [47:0]    s_tdata = '0;
    logic           s_tvalid = 1'b0;
    logic           s_tready;
    logic [47:0]    m_tdata;
    logic           m_tvalid;
    logic           m_tready = 1'b0;
    logic [TSB-1:0] ts_now;
    logic           busy;
    logic           stat_late;
    logic           stat_underrun;

    int checks = 0;
    int failures = 0;

    always #5 mclk = ~mclk;

    lms7_tx_burst_sched #(.TS_BITS(TSB), .LEN_BITS(LB)) dut (
        .mclk(mclk), .rst_n(rst_n), .enable(enable), .ts_tick(ts_tick),
        .cmd_ts(cmd_ts), .cmd_len(cmd_len), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
        .ts_now(ts_now), .busy(busy), .stat_late(stat_late), .stat_underrun(stat_underrun)
    );

    // Reference model: one pending burst, its target slot and samples left.
    int md_ts, md_tgt, md_left;
    bit md_burst, md_started, md_late, md_run, md_plate, md_punder;

    logic ob_crdy, ob_busy, ob_mv, ob_sr, ob_late, ob_under, ob_hs;
    logic [TSB-1:0] ob_ts;

    typedef struct {
        logic en, tick, cv;
        logic [TSB-1:0] cts;
        logic [LB-1:0] clen;
        logic sv;
        logic [47:0] sd;
        logic mr;
        logic e_crdy, e_busy, e_mv, e_sr, e_under;
        logic [TSB-1:0] e_ts;
        logic [47:0] e_md;
    } vec_t;

    vec_t tbl[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout expected=event", name);
    endtask

    task automatic model_reset();
        md_ts = 0; md_tgt = 0; md_left = 0;
        md_burst = 0; md_started = 0; md_late = 0;
        md_run = 0; md_plate = 0; md_punder = 0;
    endtask

    task automatic model_check();
        bit strm, disc;
        strm = md_burst && md_started;
        disc = md_burst && md_late;
        chk("mdl_cmd_ready", 64'(cmd_ready), 64'(!md_burst && enable && md_run));
        chk("mdl_busy", 64'(busy), 64'(md_burst));
        chk("mdl_m_tvalid", 64'(m_tvalid), 64'(strm ? s_tvalid : 1'b0));
        chk("mdl_m_tdata", 64'(m_tdata), 64'(strm ? s_tdata : 48'h0));
        chk("mdl_s_tready", 64'(s_tready), 64'(strm ? m_tready : (disc ? 1'b1 : 1'b0)));
        chk("mdl_ts_now", 64'(ts_now), 64'(md_ts));
        chk("mdl_stat_late", 64'(stat_late), 64'(md_plate));
        chk("mdl_stat_underrun", 64'(stat_underrun), 64'(md_punder));
    endtask

    task automatic model_advance();
        bit crdy, waiting, strm, disc;
        int nts, d;
        crdy    = !md_burst && enable && md_run;
        waiting = md_burst && !md_started && !md_late;
        strm    = md_burst && md_started;
        disc    = md_burst && md_late;
        nts     = (md_ts + ((enable && ts_tick) ? 1 : 0)) % TSM;
        md_plate  = 0;
        md_punder = 0;
        if (!enable) begin
            md_burst = 0;
        end else if (waiting) begin
            d = (md_tgt - nts + TSM) % TSM;
            if (d == 0) md_started = 1;
            else if (d >= TSM / 2) begin md_late = 1; md_plate = 1; end
        end else if (strm) begin
            if (s_tvalid && m_tready) begin
                md_left--;
                if (md_left == 0) md_burst = 0;
            end else if (m_tready) begin
                md_punder = 1;
            end
        end else if (disc) begin
            if (s_tvalid) begin
                md_left--;
                if (md_left == 0) md_burst = 0;
            end
        end else if (crdy && cmd_valid && cmd_len != 0) begin
            md_burst = 1; md_started = 0; md_late = 0;
            md_tgt = int'(cmd_ts); md_left = int'(cmd_len);
        end
        md_ts  = nts;
        md_run = 1;
    endtask

    // One clock cycle: inputs already driven at posedge+1, sampled on the falling edge.
    task automatic step();
        #4;
        model_check();
        ob_crdy = cmd_ready; ob_busy = busy; ob_mv = m_tvalid; ob_sr = s_tready;
        ob_late = stat_late; ob_under = stat_underrun; ob_hs = s_tvalid & s_tready;
        ob_ts = ts_now;
        model_advance();
        @(posedge mclk);
        #1;
    endtask

    task automatic idle_inputs();
        enable = 1'b1; ts_tick = 1'b1; cmd_valid = 1'b0;
        s_tvalid = 1'b0; m_tready = 1'b0; s_tdata = 48'h0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        enable = 1'b1; ts_tick = 1'b1; cmd_valid = 1'b1;
        s_tvalid = 1'b1; m_tready = 1'b1; s_tdata = 48'hABCDEF012345;
        #1;
        chk("rst_cmd_ready", 64'(cmd_ready), 64'(0));
        chk("rst_s_tready", 64'(s_tready), 64'(0));
        chk("rst_m_tvalid", 64'(m_tvalid), 64'(0));
        chk("rst_m_tdata", 64'(m_tdata), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_ts_now", 64'(ts_now), 64'(0));
        chk("rst_stat_late", 64'(stat_late), 64'(0));
        chk("rst_stat_underrun", 64'(stat_underrun), 64'(0));
        model_reset();
        repeat (2) @(posedge mclk);
        #1;
        chk("rst_hold_ts_now", 64'(ts_now), 64'(0));
        chk("rst_hold_cmd_ready", 64'(cmd_ready), 64'(0));
        idle_inputs();
        rst_n = 1'b1;
    endtask

    task automatic send_cmd(input logic [TSB-1:0] t, input logic [LB-1:0] l);
        bit got;
        got = 0;
        cmd_ts = t; cmd_len = l; cmd_valid = 1'b1;
        for (int k = 0; k < 20 && !got; k++) begin
            step();
            if (ob_crdy) got = 1;
        end
        cmd_valid = 1'b0;
        if (!got) timeout_fail("cmd_handshake");
    endtask

    task automatic run_to_ts(input int t);
        for (int k = 0; k < 5000 && md_ts != t; k++) step();
        if (md_ts != t) timeout_fail("run_to_ts");
    endtask

    function automatic vec_t mk(input logic en, tick, cv, input logic [TSB-1:0] cts,
                                input logic [LB-1:0] clen, input logic sv,
                                input logic [47:0] sd, input logic mr,
                                input logic e_crdy, e_busy, e_mv, e_sr, e_under,
                                input logic [TSB-1:0] e_ts, input logic [47:0] e_md);
        vec_t v;
        v.en = en; v.tick = tick; v.cv = cv; v.cts = cts; v.clen = clen;
        v.sv = sv; v.sd = sd; v.mr = mr;
        v.e_crdy = e_crdy; v.e_busy = e_busy; v.e_mv = e_mv; v.e_sr = e_sr;
        v.e_under = e_under; v.e_ts = e_ts; v.e_md = e_md;
        return v;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs, late, under, kend;
        bit seen;

        //          en tk cv cts clen sv sd                 mr  crdy busy mv sr und ts  md
        tbl[0]  = mk(1, 1, 0, 0, 0, 0, 48'h0,             0,  0, 0, 0, 0, 0, 0, 48'h0);
        tbl[1]  = mk(1, 1, 1, 5, 0, 1, 48'hAAAA,          1,  1, 0, 0, 0, 0, 1, 48'h0);
        tbl[2]  = mk(1, 0, 0, 0, 0, 0, 48'h0,             0,  1, 0, 0, 0, 0, 2, 48'h0);
        tbl[3]  = mk(1, 1, 1, 5, 2, 1, 48'h5555,          1,  1, 0, 0, 0, 0, 2, 48'h0);
        tbl[4]  = mk(1, 1, 0, 0, 0, 1, 48'h5555,          1,  0, 1, 0, 0, 0, 3, 48'h0);
        tbl[5]  = mk(1, 1, 0, 0, 0, 1, 48'h5555,          1,  0, 1, 0, 0, 0, 4, 48'h0);
        tbl[6]  = mk(1, 1, 0, 0, 0, 1, 48'h111111111111,  1,  0, 1, 1, 1, 0, 5, 48'h111111111111);
        tbl[7]  = mk(1, 1, 0, 0, 0, 0, 48'h0000DEAD0000,  1,  0, 1, 0, 1, 0, 6, 48'h0000DEAD0000);
        tbl[8]  = mk(1, 1, 0, 0, 0, 1, 48'h222222222222,  0,  0, 1, 1, 0, 1, 7, 48'h222222222222);
        tbl[9]  = mk(1, 1, 1, 3, 3, 1, 48'h333333333333,  1,  0, 1, 1, 1, 0, 8, 48'h333333333333);
        tbl[10] = mk(1, 0, 0, 0, 0, 1, 48'h444444444444,  1,  1, 0, 0, 0, 0, 9, 48'h0);
        tbl[11] = mk(0, 1, 0, 0, 0, 0, 48'h0,             0,  0, 0, 0, 0, 0, 9, 48'h0);
        tbl[12] = mk(1, 0, 0, 0, 0, 0, 48'h0,             0,  1, 0, 0, 0, 0, 9, 48'h0);

        @(posedge mclk);
        #1;
        do_reset();
        for (int i = 0; i < 13; i++) begin
            enable = tbl[i].en; ts_tick = tbl[i].tick; cmd_valid = tbl[i].cv;
            cmd_ts = tbl[i].cts; cmd_len = tbl[i].clen; s_tvalid = tbl[i].sv;
            s_tdata = tbl[i].sd; m_tready = tbl[i].mr;
            step();
            chk($sformatf("tbl%0d_cmd_ready", i), 64'(ob_crdy), 64'(tbl[i].e_crdy));
            chk($sformatf("tbl%0d_busy", i), 64'(ob_busy), 64'(tbl[i].e_busy));
            chk($sformatf("tbl%0d_m_tvalid", i), 64'(ob_mv), 64'(tbl[i].e_mv));
            chk($sformatf("tbl%0d_s_tready", i), 64'(ob_sr), 64'(tbl[i].e_sr));
            chk($sformatf("tbl%0d_underrun", i), 64'(ob_under), 64'(tbl[i].e_under));
            chk($sformatf("tbl%0d_ts_now", i), 64'(ob_ts), 64'(tbl[i].e_ts));
        end

        // Aligned burst: cmd_ts=10, cmd_len=4.
        do_reset();
        s_tvalid = 1'b1; m_tready = 1'b1;
        send_cmd(12'd10, 8'd4);
        hs = 0; seen = 0; kend = -1;
        for (int k = 0; k < 40 && kend < 0; k++) begin
            s_tdata = 48'(k + 100);
            step();
            if (ob_mv && !seen) begin seen = 1; chk("a_first_ts", 64'(ob_ts), 64'(10)); end
            if (ob_hs) hs++;
            if (!ob_busy) begin kend = k; chk("a_cmd_ready_after", 64'(ob_crdy), 64'(1)); end
        end
        if (kend < 0) timeout_fail("a_burst_end");
        chk("a_seen_valid", 64'(seen), 64'(1));
        chk("a_handshakes", 64'(hs), 64'(4));

        // Late burst: target 50 issued at ts_now=100 is drained.
        idle_inputs();
        run_to_ts(100);
        send_cmd(12'd50, 8'd3);
        hs = 0; late = 0; seen = 0; kend = -1;
        for (int k = 0; k < 40 && kend < 0; k++) begin
            s_tvalid = (k % 2 == 0); s_tdata = 48'hBEEF00 + 48'(k); m_tready = 1'b0;
            step();
            late += int'(ob_late); hs += int'(ob_hs);
            if (ob_mv) seen = 1;
            if (!ob_busy) kend = k;
        end
        if (kend < 0) timeout_fail("b_burst_end");
        for (int k = 0; k < 2; k++) begin step(); late += int'(ob_late); end
        chk("b_late_pulses", 64'(late), 64'(1));
        chk("b_consumed", 64'(hs), 64'(3));
        chk("b_m_tvalid_never", 64'(seen), 64'(0));

        // Underrun: s_tvalid drops for 3 cycles while m_tready=1.
        idle_inputs();
        send_cmd(TSB'((md_ts + 4) % TSM), 8'd4);
        for (int k = 0; k < 20 && !md_started; k++) step();
        if (!md_started) timeout_fail("c_reach_active");
        hs = 0; under = 0; kend = -1;
        for (int k = 0; k < 30 && kend < 0; k++) begin
            s_tvalid = !(k >= 1 && k <= 3); m_tready = 1'b1; s_tdata = 48'hC00000 + 48'(k);
            step();
            under += int'(ob_under); hs += int'(ob_hs);
            if (!ob_busy) kend = k;
        end
        if (kend < 0) timeout_fail("c_burst_end");
        chk("c_underruns", 64'(under), 64'(3));
        chk("c_handshakes", 64'(hs), 64'(4));
        chk("c_end_cycle", 64'(kend), 64'(7));

        // Zero-length descriptor.
        idle_inputs();
        s_tvalid = 1'b1; m_tready = 1'b1;
        send_cmd(12'd123, 8'd0);
        step();
        chk("e_busy", 64'(ob_busy), 64'(0));
        chk("e_cmd_ready", 64'(ob_crdy), 64'(1));
        late = int'(ob_late) + int'(ob_under) + int'(ob_sr);
        for (int k = 0; k < 3; k++) begin step(); late += int'(ob_late) + int'(ob_under) + int'(ob_sr); end
        chk("e_no_activity", 64'(late), 64'(0));

        // Target across the timestamp wrap.
        idle_inputs();
        run_to_ts(TSM - 2);
        s_tvalid = 1'b1; m_tready = 1'b1;
        send_cmd(12'd1, 8'd2);
        hs = 0; late = 0; seen = 0; kend = -1;
        for (int k = 0; k < 20 && kend < 0; k++) begin
            s_tdata = 48'hD0 + 48'(k);
            step();
            if (ob_mv && !seen) begin seen = 1; chk("d_first_ts", 64'(ob_ts), 64'(1)); end
            late += int'(ob_late); hs += int'(ob_hs);
            if (!ob_busy) kend = k;
        end
        if (kend < 0) timeout_fail("d_burst_end");
        chk("d_seen_valid", 64'(seen), 64'(1));
        chk("d_no_late", 64'(late), 64'(0));
        chk("d_handshakes", 64'(hs), 64'(2));

        // Reset asserted mid-burst, then a normal burst.
        idle_inputs();
        s_tvalid = 1'b1; m_tready = 1'b1;
        send_cmd(TSB'((md_ts + 3) % TSM), 8'd6);
        hs = 0;
        for (int k = 0; k < 20 && hs < 2; k++) begin step(); hs += int'(ob_hs); end
        if (hs < 2) timeout_fail("f_mid_burst");
        do_reset();
        step();
        chk("f_ts_after_reset", 64'(ob_ts), 64'(0));
        s_tvalid = 1'b1; m_tready = 1'b1;
        send_cmd(12'd6, 8'd2);
        hs = 0; seen = 0; kend = -1;
        for (int k = 0; k < 20 && kend < 0; k++) begin
            step();
            if (ob_mv && !seen) begin seen = 1; chk("f_first_ts", 64'(ob_ts), 64'(6)); end
            hs += int'(ob_hs);
            if (!ob_busy) kend = k;
        end
        if (kend < 0) timeout_fail("f_burst_end");
        chk("f_handshakes", 64'(hs), 64'(2));

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            enable    = ($urandom_range(0, 19) != 0);
            ts_tick   = ($urandom_range(0, 3) != 0);
            cmd_valid = $urandom_range(0, 1);
            cmd_ts    = TSB'((md_ts + $urandom_range(0, 30) + TSM - 6) % TSM);
            cmd_len   = LB'($urandom_range(0, 5));
            s_tvalid  = $urandom_range(0, 1);
            m_tready  = $urandom_range(0, 1);
            s_tdata   = {16'($urandom), 32'($urandom)};
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
